wib_rd_sched: RTL and testbench



---
 rtl/npu_wib_pkg.sv | 17 +
 rtl/wib_skid_fifo.sv | 74 +++++++
 rtl/wib_rd_sched.sv | 180 ++++++++++++++++++
 tb/tb_wib_rd_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_wib_pkg.sv
// rtl/npu_wib_pkg.sv - shared WIB widths, scheduler state encoding and default read latency
//
// Purpose : constants shared by the WIB read scheduler and its skid FIFO.
// Contents: WIB_AW/WIB_DW buffer geometry, WIB_FW FIFO entry width ({last, data}),
//           RD_LAT_DEF default buffer read latency, scheduler state codes.
package npu_wib_pkg;

  localparam int WIB_AW     = 10;
  localparam int WIB_DW     = 19;
  localparam int WIB_FW     = WIB_DW + 1;
  localparam int RD_LAT_DEF = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/wib_skid_fifo.sv
// rtl/wib_skid_fifo.sv - synchronous skid FIFO with fall-through head and occupancy count
//
// Purpose : holds returned buffer words until the downstream accepts them. When the
//           FIFO is empty a pushed word is presented on the head in the same cycle,
//           and if it is popped in that cycle it is never stored.
// Ports   : i_clk, i_rst_n (async active-low)
//           i_push/i_pdata  write side (caller guarantees no push into a full FIFO)
//           i_pop           remove head (ignored when o_vld=0)
//           o_head/o_vld    current head word and its valid
//           o_count         number of stored entries (excludes a bypassing word)
module wib_skid_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_pdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_vld,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  assign w_empty  = (r_count == '0);
  // Empty FIFO, word arrives and leaves in the same cycle: nothing is stored.
  assign w_bypass = w_empty && i_push && i_pop;
  assign w_wr     = i_push && !w_bypass;
  assign w_rd     = i_pop && !w_empty;

  assign o_vld   = !w_empty || i_push;
  assign o_head  = !w_empty ? r_mem[r_rd_ptr] : (i_push ? i_pdata : '0);
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_pdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_rd) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wib_rd_sched.sv
// rtl/wib_rd_sched.sv - WIB block-read scheduler and host/core port arbiter
//
// Purpose : accepts block-read commands (base, len, rpt), issues buffer reads when the
//           host path is idle and FIFO credit exists, re-aligns returned data with a
//           RD_LAT-deep tag pipe and streams words out with valid/ready.
// Ports   : i_clk, i_rst_n (async active-low)
//           i_cmd_vld/o_cmd_rdy, i_cmd_base, i_cmd_len, i_cmd_rpt  command handshake
//           i_host_en                                              host owns the port
//           o_wib_rd_en, o_wib_raddr, i_wib_rdat                   buffer read port
//           o_dat, o_dat_vld, o_dat_last, i_dat_rdy                output stream
//           o_busy, o_done, o_conflict_cnt                         status
module wib_rd_sched
  import npu_wib_pkg::*;
#(
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_vld,
  output logic              o_cmd_rdy,
  input  logic [WIB_AW-1:0] i_cmd_base,
  input  logic [WIB_AW-1:0] i_cmd_len,
  input  logic [3:0]        i_cmd_rpt,
  input  logic              i_host_en,
  output logic              o_wib_rd_en,
  output logic [WIB_AW-1:0] o_wib_raddr,
  input  logic [WIB_DW-1:0] i_wib_rdat,
  output logic [WIB_DW-1:0] o_dat,
  output logic              o_dat_vld,
  output logic              o_dat_last,
  input  logic              i_dat_rdy,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_conflict_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]        r_state;
  logic [WIB_AW-1:0] r_base;
  logic [WIB_AW-1:0] r_len;
  logic [WIB_AW-1:0] r_offset;
  logic [3:0]        r_rpt;
  logic [3:0]        r_pass;
  logic [RD_LAT-1:0] r_sr_vld;
  logic [RD_LAT-1:0] r_sr_last;
  logic [CW-1:0]     r_inflight;
  logic [15:0]       r_conflict_cnt;
  logic              r_done;

  logic              w_credit;
  logic              w_issue;
  logic              w_final;
  logic              w_push;
  logic              w_pop;
  logic              w_drained;
  logic              w_fifo_vld;
  logic [CW-1:0]     w_fifo_count;
  logic [WIB_FW-1:0] w_head;

  // Stored words plus reads still in the buffer pipe never exceed the FIFO depth,
  // so a returning word always has a free slot.
  assign w_credit = (32'(w_fifo_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH);
  assign w_issue  = (r_state == ST_RUN) && !i_host_en && w_credit;
  assign w_final  = (r_offset == r_len) && (r_pass == r_rpt);
  assign w_push   = r_sr_vld[RD_LAT-1];
  assign w_pop    = w_fifo_vld && i_dat_rdy;

  // Evaluated on the values after this edge so o_done lands the cycle after the
  // last handshake (issue is always 0 in DRAIN).
  assign w_drained = (32'(r_inflight) - 32'(w_push) == 32'd0) &&
                     (32'(w_fifo_count) + 32'(w_push) - 32'(w_pop) == 32'd0);

  assign o_cmd_rdy      = (r_state == ST_IDLE);
  assign o_busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done         = r_done;
  assign o_wib_rd_en    = w_issue;
  assign o_wib_raddr    = r_base + r_offset;
  assign o_dat_vld      = w_fifo_vld;
  assign o_dat          = w_head[WIB_DW-1:0];
  assign o_dat_last     = w_head[WIB_DW];
  assign o_conflict_cnt = r_conflict_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_base   <= '0;
      r_len    <= '0;
      r_rpt    <= '0;
      r_offset <= '0;
      r_pass   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_vld) begin
            r_base   <= i_cmd_base;
            r_len    <= i_cmd_len;
            r_rpt    <= i_cmd_rpt;
            r_offset <= '0;
            r_pass   <= '0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            if (r_offset == r_len) begin
              r_offset <= '0;
              r_pass   <= r_pass + 1'b1;
            end else begin
              r_offset <= r_offset + 1'b1;
            end
            if (w_final) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tag pipe: bit RD_LAT-1 is high in the cycle the matching word sits on i_wib_rdat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr_vld  <= '0;
      r_sr_last <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_sr_vld[i]  <= r_sr_vld[i-1];
        r_sr_last[i] <= r_sr_last[i-1];
      end
      r_sr_vld[0]  <= w_issue;
      r_sr_last[0] <= w_issue && w_final;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= '0;
    end else if (w_issue && !w_push) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (!w_issue && w_push) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  // Counts slots the host stole while the scheduler had credit to read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_conflict_cnt <= '0;
    end else if ((r_state == ST_RUN) && i_host_en && w_credit &&
                 (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  wib_skid_fifo #(
    .WIDTH (WIB_FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pdata ({r_sr_last[RD_LAT-1], i_wib_rdat}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_vld   (w_fifo_vld),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_wib_rd_sched.sv
// tb/tb_wib_rd_sched.sv - directed self-checking bench for wib_rd_sched
module tb_wib_rd_sched;
  import npu_wib_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_cmd_vld = 1'b0;
  logic              o_cmd_rdy;
  logic [WIB_AW-1:0] i_cmd_base = '0;
  logic [WIB_AW-1:0] i_cmd_len = '0;
  logic [3:0]        i_cmd_rpt = '0;
  logic              i_host_en = 1'b0;
  logic              o_wib_rd_en;
  logic [WIB_AW-1:0] o_wib_raddr;
  logic [WIB_DW-1:0] i_wib_rdat = '0;
  logic [WIB_DW-1:0] o_dat;
  logic              o_dat_vld;
  logic              o_dat_last;
  logic              i_dat_rdy = 1'b1;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_conflict_cnt;

  always #5 i_clk = ~i_clk;

  wib_rd_sched #(.RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_cmd_vld      (i_cmd_vld),
    .o_cmd_rdy      (o_cmd_rdy),
    .i_cmd_base     (i_cmd_base),
    .i_cmd_len      (i_cmd_len),
    .i_cmd_rpt      (i_cmd_rpt),
    .i_host_en      (i_host_en),
    .o_wib_rd_en    (o_wib_rd_en),
    .o_wib_raddr    (o_wib_raddr),
    .i_wib_rdat     (i_wib_rdat),
    .o_dat          (o_dat),
    .o_dat_vld      (o_dat_vld),
    .o_dat_last     (o_dat_last),
    .i_dat_rdy      (i_dat_rdy),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_conflict_cnt (o_conflict_cnt)
  );

  function automatic logic [WIB_DW-1:0] data_of(input logic [WIB_AW-1:0] a);
    data_of = {a[8:0], a} ^ 19'h5A5A5;
  endfunction

  // Buffer model with output register: data appears two edges after the read.
  logic [WIB_DW-1:0] r_pipe = '0;
  always @(posedge i_clk) begin
    if (o_wib_rd_en) r_pipe <= data_of(o_wib_raddr);
    i_wib_rdat <= r_pipe;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [WIB_AW-1:0] q_addr[$];
  int                q_acyc[$];
  logic [WIB_FW-1:0] q_out[$];
  int                q_hcyc[$];
  int                viol = 0;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_wib_rd_en) begin
        q_addr.push_back(o_wib_raddr);
        q_acyc.push_back(cyc);
      end
      if (o_wib_rd_en && i_host_en) viol++;
      if (o_dat_vld && i_dat_rdy) begin
        q_out.push_back({o_dat_last, o_dat});
        q_hcyc.push_back(cyc);
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int t_acc = 0;
  int done_cyc = -1;
  logic rdy_at_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_acyc.delete();
    q_out.delete();
    q_hcyc.delete();
  endtask

  task automatic send_cmd(input logic [9:0] b, input logic [9:0] l, input logic [3:0] r);
    step();
    i_cmd_vld  = 1'b1;
    i_cmd_base = b;
    i_cmd_len  = l;
    i_cmd_rpt  = r;
    t_acc      = cyc;
    step();
    i_cmd_vld  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    done_cyc = -1;
    while (n < 400) begin
      @(negedge i_clk);
      if (o_done) begin
        done_cyc    = cyc;
        rdy_at_done = o_cmd_rdy;
        break;
      end
      n++;
    end
    chk({tag, " done seen"}, 32'(done_cyc >= 0), 32'(1));
  endtask

  task automatic chk_stream(input string tag, input logic [9:0] b, input logic [9:0] l, input int passes);
    int n;
    logic [9:0] a;
    logic [WIB_FW-1:0] e;
    n = (int'(l) + 1) * passes;
    chk({tag, " word count"}, 32'(q_out.size()), 32'(n));
    chk({tag, " issue count"}, 32'(q_addr.size()), 32'(n));
    for (int i = 0; i < n && i < q_out.size() && i < q_addr.size(); i++) begin
      a = b + 10'(i % (int'(l) + 1));
      e = {(i == n - 1), data_of(a)};
      chk($sformatf("%s addr%0d", tag, i), 32'(q_addr[i]), 32'(a));
      chk($sformatf("%s word%0d", tag, i), 32'(q_out[i]), 32'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_iss;
    int n_rel;

    // Reset values
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst cmd_rdy", 32'(o_cmd_rdy), 32'(1));
    chk("rst busy", 32'(o_busy), 32'(0));
    chk("rst rd_en", 32'(o_wib_rd_en), 32'(0));
    chk("rst dat_vld", 32'(o_dat_vld), 32'(0));
    chk("rst done", 32'(o_done), 32'(0));
    chk("rst conflict", 32'(o_conflict_cnt), 32'(0));
    chk("rst dat", 32'(o_dat), 32'(0));
    chk("rst raddr", 32'(o_wib_raddr), 32'(0));

    // Basic 8-word read, no host traffic
    clear_q();
    send_cmd(10'h010, 10'd7, 4'd0);
    chk("t1 busy", 32'(o_busy), 32'(1));
    chk("t1 cmd_rdy low", 32'(o_cmd_rdy), 32'(0));
    wait_done("t1");
    chk("t1 first issue cyc", 32'(q_acyc[0]), 32'(t_acc + 1));
    chk("t1 issues back-to-back", 32'(q_acyc[7] - q_acyc[0]), 32'(7));
    chk("t1 first word cyc", 32'(q_hcyc[0]), 32'(t_acc + 3));
    chk("t1 words back-to-back", 32'(q_hcyc[7] - q_hcyc[0]), 32'(7));
    chk("t1 done after last", 32'(done_cyc), 32'(q_hcyc[7] + 1));
    chk("t1 cmd_rdy with done", 32'(rdy_at_done), 32'(1));
    chk_stream("t1", 10'h010, 10'd7, 1);
    step();
    chk("t1 busy after", 32'(o_busy), 32'(0));
    chk("t1 done one pulse", 32'(o_done), 32'(0));

    // Address wrap past 1023
    clear_q();
    send_cmd(10'h3FE, 10'd3, 4'd0);
    wait_done("t2");
    chk("t2 addr0", 32'(q_addr[0]), 32'h3FE);
    chk("t2 addr1", 32'(q_addr[1]), 32'h3FF);
    chk("t2 addr2", 32'(q_addr[2]), 32'h000);
    chk("t2 addr3", 32'(q_addr[3]), 32'h001);
    chk_stream("t2", 10'h3FE, 10'd3, 1);

    // Host every other cycle for 16 cycles during a 16-word read
    clear_q();
    send_cmd(10'h020, 10'd15, 4'd0);
    for (int k = 0; k < 16; k++) begin
      i_host_en = (k % 2 == 0);
      step();
    end
    i_host_en = 1'b0;
    wait_done("t3");
    chk("t3 conflict cnt", 32'(o_conflict_cnt), 32'(8));
    chk("t3 rd_en vs host", 32'(viol), 32'(0));
    chk_stream("t3", 10'h020, 10'd15, 1);

    // Downstream stall for 20 cycles mid-stream
    clear_q();
    send_cmd(10'h100, 10'd15, 4'd0);
    repeat (5) step();
    i_dat_rdy = 1'b0;
    repeat (5) step();
    n_iss = q_addr.size();
    repeat (15) step();
    chk("t4 outstanding", 32'(q_addr.size() - q_out.size()), 32'(4));
    chk("t4 issue stalled", 32'(q_addr.size()), 32'(n_iss));
    chk("t4 rd_en low", 32'(o_wib_rd_en), 32'(0));
    chk("t4 dat_vld held", 32'(o_dat_vld), 32'(1));
    n_rel = q_out.size();
    i_dat_rdy = 1'b1;
    wait_done("t4");
    chk("t4 no gaps", 32'(q_hcyc[15] - q_hcyc[n_rel]), 32'(15 - n_rel));
    chk_stream("t4", 10'h100, 10'd15, 1);

    // Repeat passes: (A, A+1) x3
    clear_q();
    send_cmd(10'h200, 10'd1, 4'd2);
    wait_done("t5");
    chk_stream("t5", 10'h200, 10'd1, 3);

    // Reset in the middle of a command
    clear_q();
    i_dat_rdy = 1'b0;
    send_cmd(10'h050, 10'd20, 4'd0);
    repeat (3) step();
    chk("t6 issued before rst", 32'(q_addr.size()), 32'(3));
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("t6 cmd_rdy", 32'(o_cmd_rdy), 32'(1));
    chk("t6 busy", 32'(o_busy), 32'(0));
    chk("t6 rd_en", 32'(o_wib_rd_en), 32'(0));
    chk("t6 dat_vld", 32'(o_dat_vld), 32'(0));
    chk("t6 dat_last", 32'(o_dat_last), 32'(0));
    chk("t6 done", 32'(o_done), 32'(0));
    chk("t6 conflict", 32'(o_conflict_cnt), 32'(0));
    repeat (2) step();
    i_rst_n = 1'b1;
    i_dat_rdy = 1'b1;
    clear_q();
    send_cmd(10'h3F0, 10'd4, 4'd0);
    wait_done("t6b");
    chk_stream("t6b", 10'h3F0, 10'd4, 1);

    // Host collides with the final issue
    clear_q();
    send_cmd(10'h0A0, 10'd2, 4'd0);
    step();
    step();
    i_host_en = 1'b1;
    @(negedge i_clk);
    chk("t7 final blocked", 32'(o_wib_rd_en), 32'(0));
    chk("t7 still busy", 32'(o_busy), 32'(1));
    step();
    i_host_en = 1'b0;
    wait_done("t7");
    chk("t7 conflict cnt", 32'(o_conflict_cnt), 32'(1));
    chk("t7 final issue cyc", 32'(q_acyc[2]), 32'(t_acc + 4));
    chk("t7 rd_en vs host", 32'(viol), 32'(0));
    chk_stream("t7", 10'h0A0, 10'd2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
